// File: rtl/boolean_pkg.sv
// Shared helpers for the boolean gate library.
// Covers tree depth, per-level widths and the legal input-width range.
package boolean_pkg;

    localparam int NB_IN_MAX = 64;

    function automatic int clog2_int(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int level_width(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

    // Levels are stored back to back, level 0 first.
    function automatic int level_offset(input int n, input int k);
        int s;
        s = 0;
        for (int i = 0; i < k; i++) begin
            s = s + level_width(n, i);
        end
        return s;
    endfunction

endpackage

// File: rtl/and_tree.sv
// Balanced pairwise AND reduction over NB_IN bits.
// An odd leftover element passes through to the next level unchanged.
module and_tree
    import boolean_pkg::*;
#(
    parameter int NB_IN = 8
) (
    input  logic [NB_IN-1:0] ins,
    output logic             and_out
);

    localparam int DEPTH = clog2_int(NB_IN);
    localparam int TOTAL = level_offset(NB_IN, DEPTH + 1);

    logic node [TOTAL];

    for (genvar i = 0; i < NB_IN; i++) begin : g_leaf
        assign node[i] = ins[i];
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_lvl
        localparam int WP = level_width(NB_IN, k - 1);
        localparam int OP = level_offset(NB_IN, k - 1);
        localparam int W  = level_width(NB_IN, k);
        localparam int O  = level_offset(NB_IN, k);
        for (genvar j = 0; j < W; j++) begin : g_node
            if (2 * j + 1 < WP) begin : g_pair
                assign node[O+j] = node[OP+2*j] & node[OP+2*j+1];
            end else begin : g_pass
                assign node[O+j] = node[OP+2*j];
            end
        end
    end

    assign and_out = node[TOTAL-1];

endmodule

// File: rtl/nand_nway.sv
// N-input NAND: combinational result plus a registered copy.
// Port order keeps out and ins first for legacy positional instances.
module nand_nway
    import boolean_pkg::*;
#(
    parameter int NB_IN = 8
) (
    output logic             out,
    input  logic [NB_IN-1:0] ins,
    input  logic             clk,
    input  logic             rst,
    output logic             out_comb
);

    if (NB_IN < 1 || NB_IN > NB_IN_MAX) begin : g_bad_width
        $error("nand_nway: NB_IN out of range 1..64");
    end

    logic and_res;
    logic out_d;
    logic out_q;

    and_tree #(.NB_IN(NB_IN)) u_tree (
        .ins     (ins),
        .and_out (and_res)
    );

    assign out_comb = ~and_res;

    always_comb begin
        out_d = out_comb;
        if (rst) begin
            out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_nand_nway.sv
// Self-checking bench for nand_nway at widths 8, 5, 1 and 64.
module tb_nand_nway;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  i8;
    logic [4:0]  i5;
    logic [0:0]  i1;
    logic [63:0] i64;
    logic o8, c8, o5, c5, o1, c1, o64, c64;

    nand_nway #(.NB_IN(8)) u8 (
        .out(o8), .ins(i8), .clk(clk), .rst(rst), .out_comb(c8)
    );
    nand_nway #(.NB_IN(5)) u5 (
        .out(o5), .ins(i5), .clk(clk), .rst(rst), .out_comb(c5)
    );
    nand_nway #(.NB_IN(1)) u1 (
        .out(o1), .ins(i1), .clk(clk), .rst(rst), .out_comb(c1)
    );
    nand_nway #(.NB_IN(64)) u64 (
        .out(o64), .ins(i64), .clk(clk), .rst(rst), .out_comb(c64)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: NAND is 0 only when every in-range bit is set.
    function automatic logic ref_nand(input logic [63:0] v, input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return ((v & mask) != mask);
    endfunction

    logic e8, e5, e1, e64;
    always @(posedge clk) begin
        e8  = rst ? 1'b1 : ref_nand({56'd0, i8}, 8);
        e5  = rst ? 1'b1 : ref_nand({59'd0, i5}, 5);
        e1  = rst ? 1'b1 : ref_nand({63'd0, i1}, 1);
        e64 = rst ? 1'b1 : ref_nand(i64, 64);
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_w(input int w, input logic [63:0] v);
        case (w)
            8:       i8  = v[7:0];
            5:       i5  = v[4:0];
            1:       i1  = v[0:0];
            default: i64 = v;
        endcase
    endtask

    function automatic logic get_c(input int w);
        case (w)
            8:       return c8;
            5:       return c5;
            1:       return c1;
            default: return c64;
        endcase
    endfunction

    function automatic logic get_o(input int w);
        case (w)
            8:       return o8;
            5:       return o5;
            1:       return o1;
            default: return o64;
        endcase
    endfunction

    typedef struct {
        int          w;
        logic [63:0] v;
        logic        exp;
    } vec_t;

    vec_t tbl [12];

    task automatic check_all_model(input string tag);
        check({tag, "_c8"},  c8,  ref_nand({56'd0, i8}, 8));
        check({tag, "_c5"},  c5,  ref_nand({59'd0, i5}, 5));
        check({tag, "_c1"},  c1,  ref_nand({63'd0, i1}, 1));
        check({tag, "_c64"}, c64, ref_nand(i64, 64));
        check({tag, "_o8"},  o8,  e8);
        check({tag, "_o5"},  o5,  e5);
        check({tag, "_o1"},  o1,  e1);
        check({tag, "_o64"}, o64, e64);
    endtask

    initial begin
        tbl[0]  = '{8,  64'hFF, 1'b0};
        tbl[1]  = '{8,  64'h7F, 1'b1};
        tbl[2]  = '{8,  64'hFE, 1'b1};
        tbl[3]  = '{8,  64'hEF, 1'b1};
        tbl[4]  = '{8,  64'h00, 1'b1};
        tbl[5]  = '{5,  64'h1F, 1'b0};
        tbl[6]  = '{5,  64'h0F, 1'b1};
        tbl[7]  = '{5,  64'h17, 1'b1};
        tbl[8]  = '{1,  64'h0,  1'b1};
        tbl[9]  = '{1,  64'h1,  1'b0};
        tbl[10] = '{64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[11] = '{64, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};

        rst = 1'b1;
        i8 = 8'hFF;
        i5 = '0;
        i1 = '0;
        i64 = '0;

        // Reset held for three edges with all-ones input.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_hold_out", o8, 1'b1);
            check("rst_hold_comb", c8, 1'b0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_release_out", o8, 1'b0);

        // Reset pulse that never spans an edge must not touch out.
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        check("sync_pulse_now", o8, 1'b0);
        @(negedge clk);
        check("sync_pulse_edge", o8, 1'b0);

        // Table of directed vectors; out checked one edge later.
        foreach (tbl[n]) begin
            @(posedge clk);
            #1 set_w(tbl[n].w, tbl[n].v);
            @(negedge clk);
            check($sformatf("tbl%0d_comb", n), get_c(tbl[n].w), tbl[n].exp);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_out", n), get_o(tbl[n].w), tbl[n].exp);
        end

        // Exhaustive 8-bit sweep, one value per cycle.
        for (int v = 0; v < 256; v++) begin
            @(posedge clk);
            #1 i8 = v[7:0];
            @(negedge clk);
            check($sformatf("sweep%0d_comb", v), c8, (v != 255));
            check($sformatf("sweep%0d_out", v), o8, e8);
        end

        // Random traffic with occasional resets and all-ones bias.
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 9) == 0);
            i8  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            i5  = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom);
            i1  = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                i64 = {64{1'b1}};
                if ($urandom_range(0, 1) == 0) begin
                    i64[$urandom_range(0, 63)] = 1'b0;
                end
            end else begin
                i64 = {$urandom, $urandom};
            end
            @(negedge clk);
            check_all_model($sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nand_nway.md
Name: nand_nway

Overview:
- Parameterised N-input NAND gate, the wide-fan-in primitive of the boolean library used by the CPU datapath and control decode.
- Computes out = NOT(AND of all NB_IN inputs).
- Provides a combinational result and a registered copy on a single clock with synchronous active-high reset.
- Internally built as a balanced 2-input AND reduction tree followed by one inversion.

Parameters:
- NB_IN, 8, number of input bits.
  - Legal range 1..64.
  - Values below 1 must cause an elaboration error via a generate-time check.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
- out_comb  output  1  combinational NAND of ins, zero cycles of latency.
- out  output  1  registered NAND of ins.
- ins  input  NB_IN  operand bits; ins[0] is the LSB, all bits are equally weighted.
- Declaration order is out, ins, clk, rst, out_comb, so legacy positional two-port instances still bind out and ins first.

Behaviour:
- out_comb = ~(&ins) at all times.
  - It is 0 only when every bit of ins is 1, and 1 otherwise.
  - It does not depend on clk or rst.
- out is a register updated on posedge clk:
  - if rst = 1, out <= 1 (the NAND of all-zero inputs);
  - else out <= ~(&ins).
- Reset value of out is 1.
  - Reset is synchronous, so asserting rst between edges has no effect until the next rising edge.
  - rst held for several cycles keeps out at 1 regardless of ins.
- Latency from ins to out is exactly 1 clock.
  - The value on ins in the cycle before edge k appears on out after edge k.
- Reset release: on the first edge with rst = 0, out captures the current ins.
- ins changing in the same cycle rst deasserts: out reflects the ins value present at the sampling edge.
- No handshake and no enables: out updates on every non-reset edge.
- Reduction tree:
  - Level 0 is the ins vector; each level ANDs adjacent pairs.
  - An odd leftover element passes through unchanged to the next level.
  - ceil(log2(NB_IN)) levels, then one final inversion.
- NB_IN = 1: the tree degenerates to a wire, so out_comb = ~ins[0].
- Behaviour must be independent of X-free input order; X on any input may propagate.

Decomposition:
- Shared package boolean_pkg holds a function clog2_int (tree depth) and the constant NB_IN_MAX = 64, used for the range check.
- One sub-module, and_tree, with the same NB_IN parameter:
  - ports ins[NB_IN-1:0] and and_out;
  - generate-built pairwise reduction, purely combinational.
- nand_nway instantiates and_tree, inverts its result to form out_comb, and registers it into out.

Test Plan:
- Exhaustive sweep with NB_IN = 8: drive ins = 0..255, one value per cycle, rst = 0.
  - out_comb = 0 only for ins = 8'hFF, 1 for all other values.
  - out matches the previous cycle's out_comb.
- Reset: rst = 1 with ins = 8'hFF for 3 edges -> out = 1 throughout while out_comb = 0.
  - Release rst -> out = 0 after the next edge.
- Synchronous reset check: pulse rst high between edges only (no edge while high) -> out unchanged.
- Single-bit clear with NB_IN = 8: ins = 8'hFF then 8'h7F, 8'hFE, 8'hEF -> out_comb = 0, 1, 1, 1; out follows one cycle later.
- Odd widths:
  - NB_IN = 5: ins = 5'h1F gives out_comb 0; ins = 5'h0F gives 1.
  - NB_IN = 1: ins = 0 gives 1; ins = 1 gives 0.
  - NB_IN = 64: all ones gives 0; all ones except bit 63 gives 1.
